// File: rtl/text_line_ctrl.sv
// Double-buffered text line sequencer that drives the single-glyph draw stage across one line of text.
// Optional `TEXT_BLINK_EN adds a frame-counted blink of the whole line.
module text_line_ctrl #(
  parameter int unsigned MAX_CHARS = 16,
  parameter int unsigned TEXT_X    = 100,
  parameter int unsigned TEXT_Y    = 200,
  parameter int unsigned LOOKAHEAD = 2
`ifdef TEXT_BLINK_EN
  ,
  parameter int unsigned BLINK_FRAMES = 30
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount,
  input  logic [10:0] vcount,
  input  logic        vblnk,
  input  logic        wr_en,
  input  logic [5:0]  wr_addr,
  input  logic [6:0]  wr_data,
  input  logic [6:0]  wr_len,
  input  logic        commit,
  output logic        pending,
  output logic [11:0] char_code,
  output logic [11:0] char_xpos,
  output logic [11:0] char_ypos
);

  localparam int unsigned AW = $clog2(MAX_CHARS);
  localparam int unsigned IW = AW + 1;
  localparam logic [11:0] X0    = 12'(TEXT_X);
  localparam logic [11:0] X_END = 12'(TEXT_X + 8 * MAX_CHARS);
  localparam logic [10:0] Y0    = 11'(TEXT_Y);
  localparam logic [10:0] Y1    = 11'(TEXT_Y + 15);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [2:0]    sub, sub_n;
  logic [6:0]    wr_buf   [MAX_CHARS];
  logic [6:0]    disp_buf [MAX_CHARS];
  logic [IW-1:0] disp_len, staged_len, commit_len;
  logic          vblnk_q, vblnk_rise, copy, addr_ok, in_rows, visible;
  logic [11:0]   h_la;
  logic [11:0]   char_code_n, char_xpos_n;

  assign vblnk_rise = vblnk & ~vblnk_q;
  assign copy       = vblnk_rise & (pending | commit);
  assign addr_ok    = {1'b0, wr_addr} < 7'(MAX_CHARS);
  assign commit_len = (wr_len > 7'(MAX_CHARS)) ? IW'(MAX_CHARS) : IW'(wr_len);
  assign h_la       = 12'(hcount) + 12'(LOOKAHEAD);
  assign in_rows    = (vcount >= Y0) && (vcount <= Y1);

  // Write buffer, commit staging and the vblank copy into the display buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(MAX_CHARS); i++) begin
        wr_buf[i]   <= '0;
        disp_buf[i] <= '0;
      end
      disp_len   <= '0;
      staged_len <= '0;
      pending    <= 1'b0;
      vblnk_q    <= 1'b0;
    end else begin
      vblnk_q <= vblnk;
      if (wr_en && addr_ok) wr_buf[wr_addr[AW-1:0]] <= wr_data;
      if (commit) staged_len <= commit_len;
      if (copy) begin
        // Non-blocking copy takes the pre-edge contents, so a same-cycle write is excluded
        for (int i = 0; i < int'(MAX_CHARS); i++) disp_buf[i] <= wr_buf[i];
        disp_len <= commit ? commit_len : staged_len;
        pending  <= 1'b0;
      end else if (commit) begin
        pending <= 1'b1;
      end
    end
  end

`ifdef TEXT_BLINK_EN
  localparam int unsigned FW = $clog2(BLINK_FRAMES + 1);
  logic [FW-1:0] frame_cnt;

  // Blink phase: toggles every BLINK_FRAMES vblank entries, restarted by each copy
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      visible   <= 1'b1;
    end else if (copy) begin
      frame_cnt <= '0;
      visible   <= 1'b1;
    end else if (vblnk_rise) begin
      if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
        frame_cnt <= '0;
        visible   <= ~visible;
      end else begin
        frame_cnt <= frame_cnt + FW'(1);
      end
    end
  end
`else
  assign visible = 1'b1;
`endif

  // Scan state, counters and registered draw-stage outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      sub       <= '0;
      char_code <= '0;
      char_xpos <= X0;
      char_ypos <= 12'(TEXT_Y);
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      sub       <= sub_n;
      char_code <= char_code_n;
      char_xpos <= char_xpos_n;
      char_ypos <= 12'(TEXT_Y);
    end
  end

  // Outputs are formed from the next counter values so they land one cycle after the lead-in pixel
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    sub_n       = sub;
    char_code_n = '0;
    char_xpos_n = X0;
    case (state)
      IDLE: begin
        if ((disp_len != '0) && in_rows && (h_la == X0)) begin
          state_n = RUN;
          idx_n   = '0;
          sub_n   = '0;
        end
      end
      RUN: begin
        if (h_la >= X_END) begin
          state_n = IDLE;
        end else begin
          sub_n = sub + 3'd1;
          if (sub == 3'd7) begin
            idx_n = idx + IW'(1);
            if (idx_n == disp_len) state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (state_n == RUN) begin
      char_xpos_n = X0 + 12'({idx_n, 3'b000});
      if (visible) char_code_n = {5'b0, disp_buf[idx_n[AW-1:0]]};
    end
  end

endmodule

// File: tb/tb_text_line_ctrl.sv
// Self-checking bench for text_line_ctrl: vector table, directed raster sequences, and random raster traffic
// compared cycle by cycle against a glyph-timeline reference model.
module tb_text_line_ctrl;

  localparam int MAX_CHARS    = 16;
  localparam int TEXT_X       = 100;
  localparam int TEXT_Y       = 200;
  localparam int LOOKAHEAD    = 2;
  localparam int BLINK_FRAMES = 30;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount, vcount;
  logic        vblnk, wr_en, commit;
  logic [5:0]  wr_addr;
  logic [6:0]  wr_data, wr_len;
  logic        pending;
  logic [11:0] char_code, char_xpos, char_ypos;

  text_line_ctrl #(
    .MAX_CHARS(MAX_CHARS), .TEXT_X(TEXT_X), .TEXT_Y(TEXT_Y), .LOOKAHEAD(LOOKAHEAD)
  ) dut (
    .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount), .vblnk(vblnk),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_len(wr_len),
    .commit(commit), .pending(pending), .char_code(char_code),
    .char_xpos(char_xpos), .char_ypos(char_ypos)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a line is a timeline of k cycles since the lead-in pixel, glyph k/8
  bit [6:0] m_wbuf [MAX_CHARS];
  bit [6:0] m_dbuf [MAX_CHARS];
  int m_dlen, m_staged, m_k, m_fcnt;
  bit m_pend, m_vprev, m_active, m_vis;
  logic [11:0] e_code, e_xpos;

  typedef struct packed {
    logic       we;
    logic [5:0] addr;
    logic [6:0] data;
    logic [6:0] len;
    logic       cm;
    logic       vb;
    logic       exp_pend;
  } vec_t;
  vec_t tbl [11];
  int rows [6];

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int h_la;
    int clen;
    bit rise;
    if (rst) begin
      for (int i = 0; i < MAX_CHARS; i++) begin
        m_wbuf[i] = '0;
        m_dbuf[i] = '0;
      end
      m_dlen = 0; m_staged = 0; m_k = 0; m_fcnt = 0;
      m_pend = 0; m_vprev = 0; m_active = 0; m_vis = 1;
      e_code = 12'h0;
      e_xpos = 12'(TEXT_X);
      return;
    end
    h_la = int'(hcount) + LOOKAHEAD;
    if (!m_active) begin
      if (m_dlen != 0 && int'(vcount) >= TEXT_Y && int'(vcount) < TEXT_Y + 16 && h_la == TEXT_X) begin
        m_active = 1;
        m_k = 0;
      end
    end else if (h_la >= TEXT_X + 8 * MAX_CHARS) begin
      m_active = 0;
    end else begin
      m_k++;
      if (m_k / 8 >= m_dlen) m_active = 0;
    end
    e_code = (m_active && m_vis) ? 12'(m_dbuf[m_k / 8]) : 12'h0;
    e_xpos = m_active ? 12'(TEXT_X + 8 * (m_k / 8)) : 12'(TEXT_X);
    rise = vblnk && !m_vprev;
    clen = (int'(wr_len) > MAX_CHARS) ? MAX_CHARS : int'(wr_len);
    if (commit) m_staged = clen;
    if (rise && (m_pend || commit)) begin
      m_dbuf = m_wbuf;
      m_dlen = m_staged;
      m_pend = 0;
      m_vis  = 1;
      m_fcnt = 0;
    end else begin
      if (commit) m_pend = 1;
`ifdef TEXT_BLINK_EN
      if (rise) begin
        m_fcnt++;
        if (m_fcnt == BLINK_FRAMES) begin
          m_fcnt = 0;
          m_vis  = !m_vis;
        end
      end
`endif
    end
    if (wr_en && int'(wr_addr) < MAX_CHARS) m_wbuf[int'(wr_addr)] = wr_data;
    m_vprev = vblnk;
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check({tag, "/code"}, char_code, e_code);
    check({tag, "/xpos"}, char_xpos, e_xpos);
    check({tag, "/ypos"}, char_ypos, 12'(TEXT_Y));
    check({tag, "/pending"}, 12'(pending), 12'(m_pend));
  endtask

  task automatic quiet();
    rst = 1'b0; wr_en = 1'b0; commit = 1'b0;
    wr_addr = '0; wr_data = '0; wr_len = '0;
  endtask

  task automatic write(input int addr, input int data);
    wr_en = 1'b1; wr_addr = 6'(addr); wr_data = 7'(data);
    tick("write");
    wr_en = 1'b0;
  endtask

  // One raster line with a constant probe on the glyph code after a chosen pixel
  task automatic scan_line(input int v, input int h_probe, input logic [11:0] exp_code, input string tag);
    vblnk = 1'b0;
    vcount = 11'(v);
    for (int h = 90; h <= 240; h++) begin
      hcount = 11'(h);
      tick(tag);
      if (h == h_probe) check(tag, char_code, exp_code);
    end
  endtask

  task automatic publish(input int len);
    hcount = '0; vcount = '0;
    wr_len = 7'(len); commit = 1'b1;
    tick("commit");
    commit = 1'b0; vblnk = 1'b1;
    tick("vrise");
    vblnk = 1'b0;
    tick("vfall");
  endtask

  initial begin
    logic [11:0] exp_c, exp_x;

    tbl[0]  = '{1'b0, 6'd0, 7'h00, 7'd0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 6'd0, 7'h00, 7'd3, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 6'd0, 7'h00, 7'd0, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 6'd0, 7'h00, 7'd5, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 6'd0, 7'h41, 7'd0, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 6'd0, 7'h00, 7'd0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 6'd0, 7'h00, 7'd0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 6'd0, 7'h00, 7'd4, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 6'd0, 7'h00, 7'd0, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 6'd0, 7'h00, 7'd0, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 6'd0, 7'h00, 7'd0, 1'b0, 1'b0, 1'b0};
    rows = '{150, 200, 207, 215, 216, 300};

    quiet();
    rst = 1'b1; vblnk = 1'b0; hcount = '0; vcount = '0;
    tick("reset");
    tick("reset");
    check("reset_xpos", char_xpos, 12'd100);
    rst = 1'b0;

    // Empty display: blank glyphs across the whole box
    for (int h = 90; h <= 130; h++) begin
      vcount = 11'd205; hcount = 11'(h);
      tick("empty");
      check("empty_code", char_code, 12'h0);
      check("empty_xpos", char_xpos, 12'd100);
    end

    // "HI": staged, not shown before vblank, then shown on line 205
    write(0, 8'h48);
    write(1, 8'h49);
    wr_len = 7'd2; commit = 1'b1;
    tick("hi_commit");
    commit = 1'b0;
    check("hi_pending_set", 12'(pending), 12'h1);
    scan_line(205, 98, 12'h0, "hi_staged");
    vblnk = 1'b1; hcount = '0;
    tick("hi_vrise");
    check("hi_pending_clr", 12'(pending), 12'h0);
    vblnk = 1'b0;
    tick("hi_vfall");
    vcount = 11'd205;
    for (int h = 90; h <= 130; h++) begin
      hcount = 11'(h);
      tick("hi");
      exp_c = (h >= 98 && h <= 105) ? 12'h48 : (h >= 106 && h <= 113) ? 12'h49 : 12'h0;
      exp_x = (h >= 106 && h <= 113) ? 12'd108 : 12'd100;
      check("hi_code", char_code, exp_c);
      check("hi_xpos", char_xpos, exp_x);
    end

    // Commit in the vblank-rise cycle with a same-cycle write to slot 0
    hcount = '0;
    wr_en = 1'b1; wr_addr = 6'd0; wr_data = 7'h5A; wr_len = 7'd2; commit = 1'b1; vblnk = 1'b1;
    tick("sc_edge");
    quiet();
    check("sc_pending", 12'(pending), 12'h0);
    tick("sc_hold");
    check("sc_pending_hold", 12'(pending), 12'h0);
    scan_line(205, 98, 12'h48, "sc_old");
    publish(2);
    scan_line(205, 98, 12'h5A, "sc_new");

    // Over-long length clamps to capacity; out-of-range address is dropped
    for (int i = 0; i < MAX_CHARS; i++) write(i, 8'h41 + i);
    write(20, 8'h7F);
    publish(100);
    vcount = 11'd210;
    for (int h = 90; h <= 240; h++) begin
      hcount = 11'(h);
      tick("clamp");
      if (h >= 98 && h <= 225) begin
        exp_c = 12'(8'h41 + (h - 98) / 8);
        exp_x = 12'(100 + 8 * ((h - 98) / 8));
      end else begin
        exp_c = 12'h0;
        exp_x = 12'd100;
      end
      check("clamp_code", char_code, exp_c);
      check("clamp_xpos", char_xpos, exp_x);
    end

    // Reset in the middle of glyph 3
    vcount = 11'd205;
    for (int h = 90; h <= 150; h++) begin
      hcount = 11'(h);
      rst = (h == 125);
      tick("midrst");
      if (h >= 125) begin
        check("midrst_code", char_code, 12'h0);
        check("midrst_xpos", char_xpos, 12'd100);
      end
    end
    rst = 1'b0;
    scan_line(205, 98, 12'h0, "rst_disp");
    publish(16);
    scan_line(205, 130, 12'h0, "rst_wbuf");

    // Commit/pending vector table
    hcount = '0; vcount = '0;
    for (int i = 0; i < 11; i++) begin
      wr_en = tbl[i].we; wr_addr = tbl[i].addr; wr_data = tbl[i].data;
      wr_len = tbl[i].len; commit = tbl[i].cm; vblnk = tbl[i].vb;
      tick("tbl");
      check($sformatf("tbl%0d_pending", i), 12'(pending), 12'(tbl[i].exp_pend));
    end
    quiet();
    vblnk = 1'b0;

    // Random raster traffic against the model
    for (int f = 0; f < 24; f++) begin
      for (int l = 0; l < 6; l++) begin
        vcount = 11'(rows[l]);
        vblnk = 1'b0;
        for (int h = 90; h <= 240; h++) begin
          hcount  = 11'(h);
          wr_en   = ($urandom_range(0, 7) == 0);
          wr_addr = 6'($urandom_range(0, 31));
          wr_data = 7'($urandom_range(0, 127));
          wr_len  = ($urandom_range(0, 1) == 0) ? 7'($urandom_range(0, 20)) : 7'($urandom_range(0, 127));
          commit  = ($urandom_range(0, 199) == 0);
          rst     = ($urandom_range(0, 4999) == 0);
          tick("rnd");
        end
      end
      vcount = 11'd500;
      for (int c = 0; c < 10; c++) begin
        vblnk   = 1'b1;
        hcount  = 11'($urandom_range(0, 2047));
        wr_en   = ($urandom_range(0, 3) == 0);
        wr_addr = 6'($urandom_range(0, 31));
        wr_data = 7'($urandom_range(0, 127));
        wr_len  = 7'($urandom_range(0, 127));
        commit  = ($urandom_range(0, 15) == 0);
        rst     = 1'b0;
        tick("rnd_vb");
      end
      quiet();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/text_line_ctrl.md
Name: text_line_ctrl

Overview:
- Sequences the single-character draw stage so that it renders a full line of text, up to MAX_CHARS glyphs, on screen.
- Game logic writes character codes into a write buffer, then pulses commit. On the next vertical-blank entry the block copies the write buffer into a display buffer (double-buffered, tear-free).
- During scanout it steps a character counter every 8 pixels and drives char_code/char_xpos/char_ypos to the draw stage, with a pixel look-ahead that covers font ROM latency.

Parameters:
- MAX_CHARS, 16, display capacity in characters (power of two, 2..64).
- TEXT_X, 100, left pixel column of the text box.
- TEXT_Y, 200, top pixel row of the text box (glyph height 16 rows).
- LOOKAHEAD, 2, pixels by which the character selection leads in.hcount.
- BLINK_FRAMES, 30, frames per blink half-period (used only with TEXT_BLINK_EN).

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- hcount  in  11  current horizontal pixel count
- vcount  in  11  current vertical line count
- vblnk  in  1  vertical blanking flag
- wr_en  in  1  write strobe for the write buffer
- wr_addr  in  6  character slot; only the low $clog2(MAX_CHARS) bits are used; values >= MAX_CHARS are ignored
- wr_data  in  7  ASCII/font code
- wr_len  in  7  string length captured at commit
- commit  in  1  single-cycle request to publish the write buffer
- pending  out  1  high from commit until the copy completes
- char_code  out  12  glyph code to the draw stage (upper 5 bits zero)
- char_xpos  out  12  left x of the current glyph cell
- char_ypos  out  12  top y of the text line (constant TEXT_Y)

Behaviour:
- Reset:
  - Both buffers are cleared to 0 and display length is 0.
  - pending=0, char_code=0, char_xpos=TEXT_X, char_ypos=TEXT_Y.
  - Internal counters are 0 and the state is IDLE.
- Writes: when wr_en=1 and wr_addr<MAX_CHARS, the write buffer slot is updated on the clock edge. Writes are allowed at any time, including while pending=1.
- Commit:
  - commit=1 sets pending and latches min(wr_len, MAX_CHARS) as the staged length.
  - A further commit while pending=1 re-latches the length only; pending stays 1.
- Copy:
  - Triggered on the vblnk rising edge (vblnk=1, registered previous vblnk=0) when pending=1.
  - The copy is single-cycle: the display buffer and length take the write-buffer contents as they stand before that edge, so a write in the copy cycle is excluded. pending clears the same cycle.
  - commit and a vblnk rising edge in the same cycle: the copy occurs in that cycle and pending ends 0.
- Scan FSM:
  - IDLE → RUN when vcount is in [TEXT_Y, TEXT_Y+15] and hcount+LOOKAHEAD == TEXT_X. The character index and a 3-bit sub-pixel counter reset to 0.
  - In RUN, the sub-counter increments every cycle. On wrap 7→0 the index increments.
  - RUN → IDLE when the index reaches the display length, or when hblnk territory is reached (hcount+LOOKAHEAD >= TEXT_X+8*MAX_CHARS).
  - A display length of 0 never leaves IDLE.
- Outputs are registered, one cycle after the counters:
  - In RUN: char_code = {5'b0, display_buf[index]} and char_xpos = TEXT_X + 8*index.
  - In IDLE: char_code = 0 (blank glyph) and char_xpos = TEXT_X.
  - char_ypos is always TEXT_Y.
- Width rules: index is $clog2(MAX_CHARS)+1 bits; x arithmetic is 12-bit unsigned with no wrap, since TEXT_X+8*MAX_CHARS must be below 2048.
- Mid-frame reset returns the block to IDLE, so blank glyphs are output until the next valid line start.

Optional Feature:
- TEXT_BLINK_EN defined:
  - A frame counter, incremented on each vblnk rising edge, toggles a visible flag every BLINK_FRAMES frames. visible resets to 1.
  - While visible=0, char_code is forced to 0, but the counters still run.
  - A commit copy reloads visible=1 and clears the frame counter.
- TEXT_BLINK_EN undefined: no counter logic; text is always visible.

Test Plan:
- After reset, drive hcount/vcount across the text box → char_code=0, char_xpos=100, pending=0 throughout.
- Write "HI" (0x48, 0x49), wr_len=2, commit with vblnk=0 → pending=1 and display unchanged. After the vblnk rise, pending=0. At line 205, outputs are 0x48/x=100 for hcount 98..105 and 0x49/x=108 for 106..113 (each seen one cycle later), then 0 at hcount 114.
- commit asserted in the same cycle as the vblnk rising edge → the copy happens that cycle and pending=0 next cycle. A write to slot 0 in that cycle does not appear until the next commit.
- wr_len=100 with MAX_CHARS=16 → length clamps to 16, and the last glyph appears at char_xpos=220. A write to wr_addr=20 is ignored.
- Assert rst while RUN at index 3 → next cycle char_code=0 and char_xpos=100, with all display slots reading 0.
- With TEXT_BLINK_EN and BLINK_FRAMES=2 → glyphs are visible in frames 0-1, char_code=0 in frames 2-3, and visible again in frame 4.
